// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  localparam int unsigned LINE_BYTES   = 16;
  localparam int unsigned LINE_W       = LINE_BYTES * 8;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned WORD_SEL_LSB = 2;
  localparam int unsigned WSEL_W       = 2;

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever remains of the byte address above index and line offset.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
    return addr_w - $clog2(LINE_BYTES) - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, word write, block fill.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TAG_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [LINE_W-1:0] data_o,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i
);

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  // Only the line state bits are cleared; tag and data contents are don't-care until valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'd0} +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_writeback_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller between CPU and block memory.
module dcache_writeback_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [WORD_W-1:0] writedata_i,
  output logic [WORD_W-1:0] readdata_o,
  output logic              busywait_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_writedata_o,
  input  logic [LINE_W-1:0] mem_readdata_i,
  input  logic              mem_busywait_i
);

  localparam int unsigned IDX_W = idx_w(LINES);
  localparam int unsigned TAG_W = tag_w(ADDR_W, LINES);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] word_sel;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic [WORD_W-1:0] line_word;
  logic              line_valid;
  logic              line_dirty;
  logic              access;
  logic              hit;
  logic              word_we;
  logic              fill;
  logic              unused_byte_sel;

  assign req_idx         = address_i[OFF_W +: IDX_W];
  assign req_tag         = address_i[ADDR_W-1 -: TAG_W];
  assign word_sel        = address_i[WORD_SEL_LSB +: WSEL_W];
  assign unused_byte_sel = ^address_i[WORD_SEL_LSB-1:0];

  assign access    = read_i ^ write_i;
  assign hit       = line_valid && (line_tag == req_tag);
  assign line_word = line_data[{word_sel, 5'd0} +: WORD_W];

  dcache_line_array #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_i      (req_idx),
    .tag_o      (line_tag),
    .valid_o    (line_valid),
    .dirty_o    (line_dirty),
    .data_o     (line_data),
    .word_we_i  (word_we),
    .word_sel_i (word_sel),
    .word_data_i(writedata_i),
    .fill_i     (fill),
    .fill_tag_i (req_tag),
    .fill_data_i(mem_readdata_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Hits complete in IDLE without stalling; misses walk writeback -> allocate -> update.
  always_comb begin
    state_d         = state_q;
    busywait_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = '0;
    mem_writedata_o = '0;
    readdata_o      = '0;
    word_we         = 1'b0;
    fill            = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (hit) begin
            if (read_i) readdata_o = line_word;
            else        word_we    = 1'b1;
          end else begin
            busywait_o = 1'b1;
            state_d    = line_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        busywait_o      = 1'b1;
        mem_write_o     = 1'b1;
        mem_address_o   = ADDR_W'({line_tag, req_idx});
        mem_writedata_o = line_data;
        if (!mem_busywait_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        busywait_o    = 1'b1;
        mem_read_o    = 1'b1;
        mem_address_o = ADDR_W'({req_tag, req_idx});
        if (!mem_busywait_i) state_d = UPDATE;
      end
      UPDATE: begin
        busywait_o = 1'b1;
        fill       = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
